// File: rtl/icon_arb_pkg.sv
// ---------------------------------------------------------------------------
// icon_arb_pkg
// Shared types and helpers for the icon ROM arbiter.
//   NREQ_MAX   : largest supported requester count
//   DATA_W_DEF : default ROM word width (12-bit RGB 4:4:4)
//   ID_W       : requester id width, sized for NREQ_MAX
//   tag_t      : in-flight read tag {valid, id}
//   next_ptr() : round-robin pointer advance with wrap
// ---------------------------------------------------------------------------
package icon_arb_pkg;

    localparam int NREQ_MAX   = 8;
    localparam int DATA_W_DEF = 12;
    localparam int ID_W       = $clog2(NREQ_MAX);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    // Pointer moves to the requester after the one just granted, wrapping at n-1.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx, input int n);
        next_ptr = (int'(idx) == n - 1) ? ID_W'(0) : idx + ID_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches upward from i_ptr, wrapping at
// NREQ-1 -> 0, and returns the first requester found.
//   i_req [NREQ]  : request vector
//   i_ptr [ID_W]  : search start index (always < NREQ)
//   o_gnt [NREQ]  : one-hot grant, zero when nothing is requested
//   o_idx [ID_W]  : index of the granted requester
//   o_any         : at least one request present
// ---------------------------------------------------------------------------
module rr_pick
    import icon_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    logic [NREQ-1:0] w_rot;
    logic [NREQ-1:0] w_rot_one;
    logic [ID_W-1:0] w_off;
    logic [ID_W:0]   w_sum;

    // Rotate requests so bit 0 is the requester at i_ptr; the doubled vector handles the wrap.
    assign w_rot = NREQ'({i_req, i_req} >> i_ptr);

    // Lowest set bit of the rotated vector is the winner's distance from i_ptr.
    always_comb begin
        w_rot_one = w_rot & (~w_rot + NREQ'(1));
        w_off     = ID_W'(0);
        for (int i = 0; i < NREQ; i++) begin
            w_off = w_off | (w_rot_one[i] ? ID_W'(i) : ID_W'(0));
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        o_any = |i_req;
        o_idx = (w_sum >= (ID_W+1)'(NREQ)) ? ID_W'(w_sum - (ID_W+1)'(NREQ)) : w_sum[ID_W-1:0];
        o_gnt = o_any ? (NREQ'(1) << o_idx) : {NREQ{1'b0}};
    end

endmodule

// File: rtl/icon_rom_arbiter.sv
// ---------------------------------------------------------------------------
// icon_rom_arbiter
// Shares one synchronous icon ROM between NREQ icon generators. One read is
// issued per cycle; each returned word is steered back to its requester.
// Latency from grant to rvalid is ROM_LAT+1 cycles.
// Build option: define ICON_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, pointer parked at 0); default is round-robin.
// Ports:
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_req  [NREQ]        : per-requester level request
//   i_addr [NREQ*ADDR_W] : per-requester address, slice k = [k*ADDR_W +: ADDR_W]
//   o_gnt  [NREQ]        : combinational one-hot grant (accept cycle)
//   o_rom_en, o_rom_addr : registered ROM read enable / address
//   i_rom_data [DATA_W]  : ROM data, sampled ROM_LAT edges after the issue edge
//   o_rvalid [NREQ]      : one-hot return pulse
//   o_rdata [NREQ*DATA_W]: per-requester returned word, held between returns
//   o_busy               : any read in flight
// ---------------------------------------------------------------------------
module icon_rom_arbiter
    import icon_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ROM_LAT = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NREQ-1:0]        i_req,
    input  logic [NREQ*ADDR_W-1:0] i_addr,
    output logic [NREQ-1:0]        o_gnt,
    output logic                   o_rom_en,
    output logic [ADDR_W-1:0]      o_rom_addr,
    input  logic [DATA_W-1:0]      i_rom_data,
    output logic [NREQ-1:0]        o_rvalid,
    output logic [NREQ*DATA_W-1:0] o_rdata,
    output logic                   o_busy
);

    logic [NREQ-1:0]        w_pick_gnt;
    logic [ID_W-1:0]        w_pick_idx;
    logic                   w_pick_any;
    logic                   w_accept;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [ID_W-1:0]        r_ptr;
    logic                   r_rom_en;
    logic [ADDR_W-1:0]      r_rom_addr;
    tag_t                   r_pipe [ROM_LAT];
    tag_t                   w_ret;
    logic                   w_pipe_any;
    logic [NREQ-1:0]        r_rvalid;
    logic [NREQ*DATA_W-1:0] r_rdata;

`ifdef ICON_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest set request bit wins.
    always_comb begin
        w_pick_gnt = i_req & (~i_req + NREQ'(1));
        w_pick_any = |i_req;
        w_pick_idx = ID_W'(0);
        for (int k = 0; k < NREQ; k++) begin
            w_pick_idx = w_pick_idx | (w_pick_gnt[k] ? ID_W'(k) : ID_W'(0));
        end
    end

    // Pointer is parked at zero; it plays no part in the choice here.
    always_ff @(posedge i_clk) begin
        r_ptr <= ID_W'(0);
    end
`else
    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Round-robin pointer: one past the last granted requester, unchanged when idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr <= ID_W'(0);
        end else if (w_accept) begin
            r_ptr <= next_ptr(w_pick_idx, NREQ);
        end else begin
            r_ptr <= r_ptr;
        end
    end
`endif

    // Reset suppresses the grant so a requester keeps holding through reset.
    assign w_accept = w_pick_any & ~i_reset;
    assign o_gnt    = i_reset ? {NREQ{1'b0}} : w_pick_gnt;

    // One-hot AND-OR mux of the granted requester's address.
    always_comb begin
        w_sel_addr = {ADDR_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            w_sel_addr = w_sel_addr | (i_addr[k*ADDR_W +: ADDR_W] & {ADDR_W{w_pick_gnt[k]}});
        end
    end

    // Issue registers: enable pulses per accept, address holds when idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rom_en   <= 1'b0;
            r_rom_addr <= {ADDR_W{1'b0}};
        end else begin
            r_rom_en <= w_accept;
            if (w_accept) begin
                r_rom_addr <= w_sel_addr;
            end
        end
    end

    // Tag pipe: the tag leaves stage ROM_LAT-1 on the edge the ROM word is sampled.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                r_pipe[i] <= '{valid: 1'b0, id: ID_W'(0)};
            end
        end else begin
            r_pipe[0] <= '{valid: w_accept, id: w_pick_idx};
            for (int i = 1; i < ROM_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_ret = r_pipe[ROM_LAT-1];

    // Return demux: only the slice named by the exiting tag is written.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rvalid <= {NREQ{1'b0}};
            r_rdata  <= {(NREQ*DATA_W){1'b0}};
        end else begin
            r_rvalid <= w_ret.valid ? (NREQ'(1) << w_ret.id) : {NREQ{1'b0}};
            for (int k = 0; k < NREQ; k++) begin
                if (w_ret.valid && (w_ret.id == ID_W'(k))) begin
                    r_rdata[k*DATA_W +: DATA_W] <= i_rom_data;
                end
            end
        end
    end

    // Any valid tag in the pipe means a read is still outstanding.
    always_comb begin
        w_pipe_any = 1'b0;
        for (int i = 0; i < ROM_LAT; i++) begin
            w_pipe_any = w_pipe_any | r_pipe[i].valid;
        end
    end

    assign o_rom_en   = r_rom_en;
    assign o_rom_addr = r_rom_addr;
    assign o_rvalid   = r_rvalid;
    assign o_rdata    = r_rdata;
    assign o_busy     = w_pipe_any | r_rom_en;

endmodule

// File: tb/tb_icon_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_icon_rom_arbiter
// Self-checking bench for icon_rom_arbiter with NREQ=3, ROM_LAT=3.
// The ROM holds word = address*3. The reference model tracks the pointer,
// a queue of outstanding reads with their remaining latency, and the
// per-requester return registers.
// ---------------------------------------------------------------------------
module tb_icon_rom_arbiter;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 12;
    localparam int LAT    = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ-1:0]        gnt;
    logic                   rom_en;
    logic [ADDR_W-1:0]      rom_addr;
    logic [DATA_W-1:0]      rom_data;
    logic [NREQ-1:0]        rvalid;
    logic [NREQ*DATA_W-1:0] rdata;
    logic                   busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    icon_rom_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(LAT)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_req      (req),
        .i_addr     (addr),
        .o_gnt      (gnt),
        .o_rom_en   (rom_en),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data),
        .o_rvalid   (rvalid),
        .o_rdata    (rdata),
        .o_busy     (busy)
    );

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return DATA_W'(int'(a) * 3);
    endfunction

    // ROM: address register is the arbiter's rom_addr, then LAT-1 output stages.
    logic [DATA_W-1:0] rom_stg [LAT];
    always @(posedge clk) begin
        rom_stg[0] <= rom_word(rom_addr);
        for (int i = 1; i < LAT; i++) rom_stg[i] <= rom_stg[i-1];
    end
    generate
        if (LAT == 1) begin : g_rom1
            assign rom_data = rom_word(rom_addr);
        end else begin : g_romn
            assign rom_data = rom_stg[LAT-2];
        end
    endgenerate

    // ---------------- reference model ----------------
    typedef struct {
        int                rem;
        int                id;
        logic [ADDR_W-1:0] a;
    } rd_t;

    rd_t                    q[$];
    int                     m_ptr      = 0;
    logic                   m_rom_en   = 1'b0;
    logic [ADDR_W-1:0]      m_rom_addr = '0;
    logic [NREQ-1:0]        m_rvalid   = '0;
    logic [NREQ-1:0]        m_last_gnt = '0;
    logic [NREQ*DATA_W-1:0] m_rdata    = '0;

    function automatic int model_pick();
`ifdef ICON_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) if (req[k]) return k;
`else
        for (int i = 0; i < NREQ; i++) if (req[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
`endif
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_gnt();
        int k;
        k = model_pick();
        if (reset || k < 0) return '0;
        return NREQ'(1) << k;
    endfunction

    function automatic logic exp_busy();
        return (q.size() != 0) || m_rom_en;
    endfunction

    // Advance one clock edge: update the model from the inputs present at the edge.
    task automatic tick();
        int  k;
        rd_t e;
        @(posedge clk);
        if (reset) begin
            m_ptr = 0; m_rom_en = 1'b0; m_rom_addr = '0; m_rvalid = '0;
            m_rdata = '0; m_last_gnt = '0; q.delete();
        end else begin
            m_rvalid = '0;
            foreach (q[i]) q[i].rem--;
            if (q.size() > 0 && q[0].rem == 0) begin
                m_rdata[q[0].id*DATA_W +: DATA_W] = rom_word(q[0].a);
                m_rvalid = NREQ'(1) << q[0].id;
                void'(q.pop_front());
            end
            k = model_pick();
            if (k >= 0) begin
                e.rem = LAT; e.id = k; e.a = addr[k*ADDR_W +: ADDR_W];
                q.push_back(e);
                m_rom_en = 1'b1;
                m_rom_addr = e.a;
`ifdef ICON_ARB_FIXED_PRIO_EN
                m_ptr = 0;
`else
                m_ptr = (k + 1) % NREQ;
`endif
                m_last_gnt = NREQ'(1) << k;
            end else begin
                m_rom_en = 1'b0;
                m_last_gnt = '0;
            end
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; req = '0; addr = '0;
        for (int c = 0; c < 5; c++) begin
            tick(); #1;
            checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
            checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en got=%b exp=0", rom_en); end
            checks++; if (rom_addr !== 10'h000) begin errors++; $display("FAIL reset_rom_addr got=%h exp=000", rom_addr); end
            checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid got=%b exp=000", rvalid); end
            checks++; if (rdata !== 36'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        end
    endtask

    task automatic test_single();
        reset = 1'b0; req = 3'b001; addr[0 +: ADDR_W] = 10'h005;
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_gnt got=%b exp=001", gnt); end
        tick(); req = 3'b000; #1;
        checks++; if (rom_en !== 1'b1) begin errors++; $display("FAIL single_rom_en got=%b exp=1", rom_en); end
        checks++; if (rom_addr !== 10'h005) begin errors++; $display("FAIL single_rom_addr got=%h exp=005", rom_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        for (int c = 1; c <= LAT; c++) begin
            tick(); #1;
            if (c < LAT) begin
                checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL single_early_rvalid c=%0d got=%b exp=000", c, rvalid); end
            end else begin
                checks++; if (rvalid !== 3'b001) begin errors++; $display("FAIL single_rvalid got=%b exp=001", rvalid); end
                checks++; if (rdata[0 +: DATA_W] !== 12'h00F) begin errors++; $display("FAIL single_rdata0 got=%h exp=00F", rdata[0 +: DATA_W]); end
            end
        end
        tick(); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_rr_two();
        logic [NREQ-1:0] prev = '0;
        req = 3'b011; addr[0 +: ADDR_W] = 10'h040; addr[ADDR_W +: ADDR_W] = 10'h080;
        for (int c = 0; c < 8 + LAT + 2; c++) begin
            if (c == 8) req = 3'b000;
            #1;
            checks++; if (gnt !== exp_gnt()) begin errors++; $display("FAIL rr2_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt()); end
            if (c > 0 && c < 8) begin
                checks++; if (gnt === prev) begin errors++; $display("FAIL rr2_alternate c=%0d got=%b prev=%b", c, gnt, prev); end
            end
            checks++; if (rvalid !== m_rvalid) begin errors++; $display("FAIL rr2_rvalid c=%0d got=%b exp=%b", c, rvalid, m_rvalid); end
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rr2_rdata c=%0d got=%h exp=%h", c, rdata, m_rdata); end
            prev = gnt;
            tick();
            for (int k = 0; k < 2; k++) if (m_last_gnt[k]) addr[k*ADDR_W +: ADDR_W] = addr[k*ADDR_W +: ADDR_W] + 10'd7;
        end
    endtask

    task automatic test_back_to_back();
        int          got_cyc[$];
        logic [11:0] got_dat[$];
        req = 3'b010;
        for (int i = 1; i <= 3; i++) begin
            addr[ADDR_W +: ADDR_W] = ADDR_W'(i);
            #1;
            checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL b2b_gnt i=%0d got=%b exp=010", i, gnt); end
            tick();
        end
        req = 3'b000;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (rvalid === 3'b010) begin got_cyc.push_back(c); got_dat.push_back(rdata[DATA_W +: DATA_W]); end
            else begin
                checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL b2b_rvalid_other c=%0d got=%b", c, rvalid); end
            end
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL b2b_rdata c=%0d got=%h exp=%h", c, rdata, m_rdata); end
            tick();
        end
        checks++;
        if (got_cyc.size() != 3) begin
            errors++; $display("FAIL b2b_count got=%0d exp=3", got_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (got_cyc[i] != LAT - 2 + i) begin errors++; $display("FAIL b2b_cycle i=%0d got=%0d exp=%0d", i, got_cyc[i], LAT - 2 + i); end
                checks++; if (got_dat[i] !== 12'(3 * (i + 1))) begin errors++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, got_dat[i], 12'(3 * (i + 1))); end
            end
        end
    endtask

    task automatic test_reset_mid();
        req = 3'b001; addr[0 +: ADDR_W] = 10'h123;
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rmid_gnt got=%b exp=001", gnt); end
        tick();
        req = 3'b000; reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < LAT + 3; c++) begin
            #1;
            checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL rmid_rvalid c=%0d got=%b exp=000", c, rvalid); end
            checks++; if (rdata !== 36'h0) begin errors++; $display("FAIL rmid_rdata c=%0d got=%h exp=0", c, rdata); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy c=%0d got=%b exp=0", c, busy); end
            tick();
        end
        req = 3'b011; addr[ADDR_W +: ADDR_W] = 10'h0AA;
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rmid_ptr0 got=%b exp=001", gnt); end
        tick();
        req = 3'b000;
        for (int c = 0; c < LAT + 2; c++) begin
            #1;
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rmid_drain c=%0d got=%h exp=%h", c, rdata, m_rdata); end
            tick();
        end
    endtask

`ifdef ICON_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        req = 3'b011;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL fp_gnt c=%0d got=%b exp=001", c, gnt); end
            tick();
        end
        req = 3'b000;
        for (int c = 0; c < LAT + 2; c++) begin tick(); end
    endtask
`else
    task automatic test_rr_all();
        int cnt[NREQ];
        foreach (cnt[k]) cnt[k] = 0;
        req = 3'b111;
        for (int c = 0; c < 3 * NREQ; c++) begin
            #1;
            checks++; if (gnt !== exp_gnt()) begin errors++; $display("FAIL rr3_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt()); end
            for (int k = 0; k < NREQ; k++) if (gnt[k] === 1'b1) cnt[k]++;
            checks++; if (rvalid !== m_rvalid) begin errors++; $display("FAIL rr3_rvalid c=%0d got=%b exp=%b", c, rvalid, m_rvalid); end
            tick();
        end
        req = 3'b000;
        for (int k = 0; k < NREQ; k++) begin
            checks++; if (cnt[k] != 3) begin errors++; $display("FAIL rr3_share id=%0d got=%0d exp=3", k, cnt[k]); end
        end
        for (int c = 0; c < LAT + 2; c++) begin
            #1;
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rr3_rdata c=%0d got=%h exp=%h", c, rdata, m_rdata); end
            tick();
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < NREQ; k++) begin
                if (!req[k] || m_last_gnt[k]) begin
                    req[k] = ($urandom_range(0, 3) != 0);
                    addr[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 1023));
                end
            end
            #1;
            checks++; if (gnt !== exp_gnt()) begin errors++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt()); end
            checks++; if (rom_en !== m_rom_en) begin errors++; $display("FAIL rnd_rom_en c=%0d got=%b exp=%b", c, rom_en, m_rom_en); end
            checks++; if (rom_addr !== m_rom_addr) begin errors++; $display("FAIL rnd_rom_addr c=%0d got=%h exp=%h", c, rom_addr, m_rom_addr); end
            checks++; if (rvalid !== m_rvalid) begin errors++; $display("FAIL rnd_rvalid c=%0d got=%b exp=%b", c, rvalid, m_rvalid); end
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, rdata, m_rdata); end
            checks++; if (busy !== exp_busy()) begin errors++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, exp_busy()); end
            tick();
        end
        reset = 1'b0; req = '0;
        for (int c = 0; c < LAT + 2; c++) begin
            #1;
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rnd_drain c=%0d got=%h exp=%h", c, rdata, m_rdata); end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; addr = '0;
        test_reset();
        test_single();
        test_rr_two();
        test_back_to_back();
        test_reset_mid();
`ifdef ICON_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_rr_all();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
